// File: rtl/spi_mem_router_pkg.sv
// Shared encodings for the SPI memory router: frame modes, FSM states and control-byte bits.
package spi_mem_router_pkg;

   localparam logic [1:0] MODE_WR   = 2'b00;
   localparam logic [1:0] MODE_RD   = 2'b01;
   localparam logic [1:0] MODE_CTRL = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   typedef enum logic [3:0] {
      StIdle,
      StHdr,
      StAddrHi,
      StAddrLo,
      StWdata,
      StRfetch,
      StRwait,
      StRsend,
      StCtrl,
      StDrain
   } state_e;

   localparam int unsigned CTRL_ENABLE_BIT  = 0;
   localparam int unsigned CTRL_RESET_BIT   = 1;
   localparam int unsigned CTRL_SEL_EXT_BIT = 2;
   localparam int unsigned CTRL_CLR_ERR_BIT = 7;

endpackage

// File: rtl/spi_mem_router_if.sv
// Memory-side bus of the SPI router: shared address/data, one-hot write strobes, read strobe.
interface spi_mem_router_if #(
   parameter int unsigned N_CH   = 3,
   parameter int unsigned CH_W   = 2,
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned MAX_W  = 128
);
   logic [CH_W-1:0]   mem_ch_sel;
   logic [ADDR_W-1:0] mem_addr;
   logic [MAX_W-1:0]  mem_wdata;
   logic [N_CH-1:0]   mem_wren;
   logic              mem_rden;
   logic [MAX_W-1:0]  mem_rdata;

   modport master (
      output mem_ch_sel, mem_addr, mem_wdata, mem_wren, mem_rden,
      input  mem_rdata
   );

   modport slave (
      input  mem_ch_sel, mem_addr, mem_wdata, mem_wren, mem_rden,
      output mem_rdata
   );
endinterface

// File: rtl/spi_word_packer.sv
// MSB-first byte/word converter: shifts bytes into a right-aligned word, or serialises a
// loaded word from its most significant used byte. Byte count comes from the channel width.
module spi_word_packer
   import spi_mem_router_pkg::*;
#(
   parameter int unsigned        N_CH     = 3,
   parameter int unsigned        CH_W     = 2,
   parameter int unsigned        MAX_W    = 128,
   parameter logic [N_CH*8-1:0]  CH_BYTES = {8'd10, 8'd16, 8'd1}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic [CH_W-1:0]  ch_i,
   input  logic             shift_in_i,
   input  logic [7:0]       byte_i,
   input  logic             shift_out_i,
   input  logic             load_i,
   input  logic [MAX_W-1:0] load_data_i,
   output logic [MAX_W-1:0] word_o,
   output logic [7:0]       top_byte_o,
   output logic             last_o
);

   logic [MAX_W-1:0] word_q, word_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       nbytes;
   int               shamt;

   assign nbytes     = CH_BYTES[8*int'(ch_i) +: 8];
   assign last_o     = (cnt_q == nbytes - 8'd1);
   assign word_o     = word_q;
   assign top_byte_o = word_q[MAX_W-1 -: 8];

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      // Left-align on load so serialisation always takes the top byte.
      shamt  = (int'(MAX_W / 8) - int'(nbytes)) * 8;
      if (load_i) begin
         word_d = load_data_i << shamt;
         cnt_d  = 8'd0;
      end else if (shift_in_i) begin
         word_d = (cnt_q == 8'd0) ? {{(MAX_W-8){1'b0}}, byte_i} : {word_q[MAX_W-9:0], byte_i};
         cnt_d  = last_o ? 8'd0 : cnt_q + 8'd1;
      end else if (shift_out_i) begin
         word_d = word_q << 8;
         cnt_d  = last_o ? 8'd0 : cnt_q + 8'd1;
      end
      if (clear_i) begin
         cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_q <= '0;
         cnt_q  <= 8'd0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_mem_router.sv
// Byte-level command router: decodes SPI frames into auto-incrementing memory writes,
// burst readback and processor control bits.
module spi_mem_router
   import spi_mem_router_pkg::*;
#(
   parameter int unsigned       N_CH      = 3,
   parameter int unsigned       CH_W      = 2,
   parameter int unsigned       ADDR_W    = 15,
   parameter int unsigned       MAX_W     = 128,
   parameter logic [N_CH*8-1:0] CH_BYTES  = {8'd10, 8'd16, 8'd1},
   parameter int unsigned       RD_LAT    = 2,
   parameter int unsigned       RST_PULSE = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic                  frame_end,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   input  logic                  tx_req,
   output logic [7:0]            tx_byte,
   spi_mem_router_if.master      mem,
   output logic                  proc_enable,
   output logic                  proc_reset,
   output logic                  sel_ext,
   output logic                  busy,
   output logic                  err
);

   localparam int unsigned RstW = $clog2(RST_PULSE + 1);

   state_e            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [7:0]        addr_hi_q, addr_hi_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [N_CH-1:0]   wren_q, wren_d;
   logic [7:0]        lat_q, lat_d;
   logic              err_q, err_d;
   logic              en_q, en_d;
   logic              sel_q, sel_d;
   logic [RstW-1:0]   rst_cnt_q, rst_cnt_d;

   logic              pk_clear, pk_shift_in, pk_shift_out, pk_load, pk_last;
   logic [MAX_W-1:0]  pk_word;
   logic [7:0]        pk_top;

   spi_word_packer #(
      .N_CH     (N_CH),
      .CH_W     (CH_W),
      .MAX_W    (MAX_W),
      .CH_BYTES (CH_BYTES)
   ) u_packer (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (pk_clear),
      .ch_i        (ch_q),
      .shift_in_i  (pk_shift_in),
      .byte_i      (rx_byte),
      .shift_out_i (pk_shift_out),
      .load_i      (pk_load),
      .load_data_i (mem.mem_rdata),
      .word_o      (pk_word),
      .top_byte_o  (pk_top),
      .last_o      (pk_last)
   );

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      ch_d         = ch_q;
      addr_hi_d    = addr_hi_q;
      addr_d       = addr_q;
      wren_d       = '0;
      lat_d        = lat_q;
      err_d        = err_q;
      en_d         = en_q;
      sel_d        = sel_q;
      rst_cnt_d    = rst_cnt_q;
      pk_clear     = 1'b0;
      pk_shift_in  = 1'b0;
      pk_shift_out = 1'b0;
      pk_load      = 1'b0;

      if (rst_cnt_q != '0) rst_cnt_d = rst_cnt_q - 1'b1;
      // Write address advances the cycle after the strobe.
      if (|wren_q) addr_d = addr_q + 1'b1;
      if (tx_req && (state_q != StRsend)) err_d = 1'b1;

      case (state_q)
         StIdle: ;
         StHdr: begin
            if (rx_valid) begin
               if ((rx_byte[7:6] == MODE_RSVD) || (rx_byte[5:0] >= 6'(N_CH))) begin
                  err_d   = 1'b1;
                  state_d = StDrain;
               end else begin
                  mode_d  = rx_byte[7:6];
                  ch_d    = rx_byte[CH_W-1:0];
                  state_d = (rx_byte[7:6] == MODE_CTRL) ? StCtrl : StAddrHi;
               end
            end
         end
         StAddrHi: begin
            if (rx_valid) begin
               addr_hi_d = rx_byte;
               state_d   = StAddrLo;
            end
         end
         StAddrLo: begin
            if (rx_valid) begin
               addr_d  = ADDR_W'({addr_hi_q, rx_byte});
               state_d = (mode_q == MODE_WR) ? StWdata : StRfetch;
            end
         end
         StWdata: begin
            if (rx_valid) begin
               pk_shift_in = 1'b1;
               if (pk_last) wren_d = N_CH'(1) << ch_q;
            end
         end
         StRfetch: begin
            lat_d   = 8'd0;
            state_d = StRwait;
         end
         StRwait: begin
            if (lat_q == 8'(RD_LAT - 1)) begin
               pk_load = 1'b1;
               state_d = StRsend;
            end else begin
               lat_d = lat_q + 8'd1;
            end
         end
         StRsend: begin
            if (tx_req) begin
               pk_shift_out = 1'b1;
               if (pk_last) begin
                  addr_d  = addr_q + 1'b1;
                  state_d = StRfetch;
               end
            end
         end
         StCtrl: begin
            if (rx_valid) begin
               en_d  = rx_byte[CTRL_ENABLE_BIT];
               sel_d = rx_byte[CTRL_SEL_EXT_BIT];
               if (rx_byte[CTRL_RESET_BIT])   rst_cnt_d = RstW'(RST_PULSE);
               if (rx_byte[CTRL_CLR_ERR_BIT]) err_d = 1'b0;
            end
         end
         StDrain: ;
         default: state_d = StIdle;
      endcase

      // Frame boundaries override the FSM after the current byte has been consumed.
      if (frame_start) begin
         state_d  = StHdr;
         pk_clear = 1'b1;
      end else if (frame_end) begin
         state_d  = StIdle;
         pk_clear = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         mode_q    <= MODE_WR;
         ch_q      <= '0;
         addr_hi_q <= 8'd0;
         addr_q    <= '0;
         wren_q    <= '0;
         lat_q     <= 8'd0;
         err_q     <= 1'b0;
         en_q      <= 1'b0;
         sel_q     <= 1'b0;
         rst_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         ch_q      <= ch_d;
         addr_hi_q <= addr_hi_d;
         addr_q    <= addr_d;
         wren_q    <= wren_d;
         lat_q     <= lat_d;
         err_q     <= err_d;
         en_q      <= en_d;
         sel_q     <= sel_d;
         rst_cnt_q <= rst_cnt_d;
      end
   end

   assign mem.mem_ch_sel = ch_q;
   assign mem.mem_addr   = addr_q;
   assign mem.mem_wdata  = pk_word;
   assign mem.mem_wren   = wren_q;
   assign mem.mem_rden   = (state_q == StRfetch);

   assign tx_byte     = (state_q == StRsend) ? pk_top : 8'h00;
   assign proc_enable = en_q;
   assign proc_reset  = (rst_cnt_q != '0);
   assign sel_ext     = sel_q;
   assign busy        = (state_q != StIdle);
   assign err         = err_q;

endmodule

// File: tb/tb_spi_mem_router.sv
// Directed self-checking bench for spi_mem_router with a fixed-latency read memory model.
module tb_spi_mem_router;

   localparam int unsigned RD_LAT  = 2;
   localparam logic [79:0] RD_WORD = 80'h112233445566778899AA;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_start = 1'b0;
   logic       frame_end = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       tx_req = 1'b0;
   logic [7:0] tx_byte;
   logic       proc_enable, proc_reset, sel_ext, busy, err;

   int tests = 0;
   int fails = 0;
   int wren_cnt = 0;
   int rden_cnt = 0;

   logic [RD_LAT-1:0] rd_pipe = '0;

   spi_mem_router_if #(.N_CH(3), .CH_W(2), .ADDR_W(15), .MAX_W(128)) mem_if ();

   spi_mem_router dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .rx_valid    (rx_valid),
      .rx_byte     (rx_byte),
      .tx_req      (tx_req),
      .tx_byte     (tx_byte),
      .mem         (mem_if),
      .proc_enable (proc_enable),
      .proc_reset  (proc_reset),
      .sel_ext     (sel_ext),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   // Read data is valid only RD_LAT cycles after the strobe, zero otherwise.
   always @(posedge clk) rd_pipe <= {rd_pipe[RD_LAT-2:0], mem_if.mem_rden};
   assign mem_if.mem_rdata = rd_pipe[RD_LAT-1] ? {48'h0, RD_WORD} : '0;

   always @(negedge clk) begin
      if (|mem_if.mem_wren) wren_cnt <= wren_cnt + 1;
      if (mem_if.mem_rden)  rden_cnt <= rden_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic fstart();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic fend();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
   endtask

   task automatic treq();
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, {tx_byte, mem_if.mem_wren, mem_if.mem_rden, proc_enable, proc_reset,
                            sel_ext, busy, err}, '0);
      check({tag, "_addr"}, {mem_if.mem_ch_sel, mem_if.mem_addr}, '0);
      check({tag, "_wdata"}, mem_if.mem_wdata, '0);
   endtask

   initial begin
      int wc;
      int rc;
      int hi;
      logic [79:0] exp_rd;

      // Reset state
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Single-byte channel 0 writes with auto-increment
      fstart();
      check("busy_hdr", busy, 1'b1);
      send(8'h00); send(8'h00); send(8'h05);
      send(8'hAB);
      check("w0_wren", mem_if.mem_wren, 3'b001);
      check("w0_addr", mem_if.mem_addr, 15'h0005);
      check("w0_wdata", mem_if.mem_wdata, 128'hAB);
      tick();
      check("w0_wren_off", mem_if.mem_wren, 3'b000);
      check("w0_addr_inc", mem_if.mem_addr, 15'h0006);
      send(8'hCD);
      check("w1_wren", mem_if.mem_wren, 3'b001);
      check("w1_addr", mem_if.mem_addr, 15'h0006);
      check("w1_wdata", mem_if.mem_wdata, 128'hCD);
      fend();
      check("idle_after_end", busy, 1'b0);

      // 16-byte channel 1 word, then a discarded partial word
      wc = wren_cnt;
      fstart();
      send(8'h01); send(8'h00); send(8'h20);
      for (int i = 0; i < 16; i++) send(8'(i));
      check("w16_wren", mem_if.mem_wren, 3'b010);
      check("w16_addr", mem_if.mem_addr, 15'h0020);
      check("w16_wdata", mem_if.mem_wdata, 128'h000102030405060708090A0B0C0D0E0F);
      send(8'h10);
      fend();
      repeat (3) tick();
      check("w16_one_pulse", wren_cnt - wc, 1);

      // Burst read from channel 2
      fstart();
      send(8'h42); send(8'h00); send(8'h03);
      check("rd_rden", mem_if.mem_rden, 1'b1);
      check("rd_addr", mem_if.mem_addr, 15'h0003);
      check("rd_ch", mem_if.mem_ch_sel, 2'd2);
      tick(); tick();
      check("rd_pre_tx", tx_byte, 8'h00);
      tick();
      exp_rd = RD_WORD;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("rd_byte%0d", i), tx_byte, exp_rd[79 - 8*i -: 8]);
         treq();
      end
      check("rd_refetch", mem_if.mem_rden, 1'b1);
      check("rd_refetch_addr", mem_if.mem_addr, 15'h0004);
      fend();
      check("rd_abandon_tx", tx_byte, 8'h00);
      check("rd_no_err", err, 1'b0);

      // Control byte 0x07 and the reset pulse width
      fstart();
      send(8'h80);
      send(8'h07);
      check("ctl_en_sel", {proc_enable, sel_ext, proc_reset}, 3'b111);
      hi = 1;
      frame_end = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         frame_end = 1'b0;
         if (proc_reset) hi++;
      end
      check("ctl_pulse_len", hi, 16);
      check("ctl_held", {proc_enable, sel_ext}, 2'b11);

      // Underrun sets err; control 0x80 clears it
      treq();
      check("underrun_err", err, 1'b1);
      check("underrun_tx", tx_byte, 8'h00);
      fstart();
      send(8'h80);
      send(8'h80);
      check("clr_err", err, 1'b0);
      check("clr_levels", {proc_enable, sel_ext}, 2'b00);
      fend();

      // Invalid channel drains the frame
      wc = wren_cnt;
      rc = rden_cnt;
      fstart();
      send(8'h3F);
      check("bad_ch_err", err, 1'b1);
      send(8'h00); send(8'h05); send(8'h11); send(8'h22);
      check("drain_busy", busy, 1'b1);
      fend();
      tick();
      check("drain_no_mem", {wren_cnt - wc, rden_cnt - rc}, '0);

      // Next frame works; address truncation and wrap
      fstart();
      send(8'h00); send(8'hFF); send(8'hFF);
      send(8'h5A);
      check("wrap_w0", {mem_if.mem_wren, mem_if.mem_addr, mem_if.mem_wdata[7:0]},
            {3'b001, 15'h7FFF, 8'h5A});
      tick();
      check("wrap_addr0", mem_if.mem_addr, 15'h0000);
      send(8'hA5);
      check("wrap_w1", {mem_if.mem_wren, mem_if.mem_addr, mem_if.mem_wdata[7:0]},
            {3'b001, 15'h0000, 8'hA5});
      fend();
      check("err_sticky", err, 1'b1);

      // Reset mid-word while proc_reset is pulsing
      fstart();
      send(8'h80);
      send(8'h07);
      fstart();
      check("restart_busy", busy, 1'b1);
      wc = wren_cnt;
      send(8'h01); send(8'h00); send(8'h10);
      send(8'h01); send(8'h02); send(8'h03);
      check("pulse_active", proc_reset, 1'b1);
      reset = 1'b1;
      tick();
      check_all_zero("midreset");
      reset = 1'b0;
      repeat (3) tick();
      check("midreset_no_wren", wren_cnt - wc, 0);
      check("midreset_pr", proc_reset, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/spi_mem_router.md
Name: spi_mem_router

Overview:
- Byte-level command router between the SPI deserialiser and the accelerator's N_CH memories (activation, parameter, instruction, and future banks).
- Decodes a header, start address and payload per chip-select frame.
- Assembles multi-byte words per channel width and issues auto-incrementing writes.
- Serves burst readback from any channel and owns the processor control bits (enable, reset pulse, external select).
- Parametrised successor to the fixed three-memory SPI front end: channel count, word widths, address width and read latency are all generic.

Parameters:
- N_CH, 3, number of memory channels (0=act, 1=param, 2=inst by default)
- CH_W, 2, channel-select width, clog2(N_CH) minimum 1
- ADDR_W, 15, memory address width, ≤16
- MAX_W, 128, widest channel word in bits, multiple of 8
- CH_BYTES, {8'd10,8'd16,8'd1}, packed N_CH×8 bytes-per-word, channel 0 in LSBs
- RD_LAT, 2, memory read latency in clk cycles (≥1)
- RST_PULSE, 16, proc_reset pulse length in cycles

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at chip-select assertion
- frame_end  in  1  one-cycle pulse at chip-select deassertion
- rx_valid  in  1  rx_byte valid this cycle
- rx_byte  in  8  received byte
- tx_req  in  1  one-cycle pulse: SPI has latched tx_byte, advance
- tx_byte  out  8  byte to shift out next
- mem_ch_sel  out  CH_W  channel targeted by mem_addr/mem_rden
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  MAX_W  write word, right-aligned, upper bits zero
- mem_wren  out  N_CH  one-hot write strobe
- mem_rden  out  1  read strobe
- mem_rdata  in  MAX_W  read word, right-aligned, valid RD_LAT cycles after mem_rden
- proc_enable  out  1  processor enable
- proc_reset  out  1  processor reset pulse, active-high
- sel_ext  out  1  external memory-port select
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky error flag, cleared by reset or a control command with bit7=1

Behaviour:
- Reset: every output is 0, state is IDLE, and all counters are cleared.
- Frame format:
  - Header byte: [7:6] mode (00 write, 01 read, 10 control, 11 reserved); [5:0] channel.
  - Then ADDR_HI and ADDR_LO, big-endian, truncated to ADDR_W. Control mode has no address bytes.
- FSM states: IDLE, HDR, ADDR_HI, ADDR_LO, WDATA, RFETCH, RWAIT, RSEND, CTRL, DRAIN.
  - IDLE → HDR on frame_start.
  - HDR → ADDR_HI on a valid header; HDR → CTRL for mode 10.
  - Mode 11, or channel ≥ N_CH, sets err and goes to DRAIN.
  - ADDR_LO → WDATA (write) or RFETCH (read).
- Write path:
  - Bytes shift into the word MSB-first.
  - After CH_BYTES[ch] bytes, mem_wren[ch] pulses for exactly 1 cycle with mem_addr and mem_wdata; mem_addr increments the cycle after.
  - Write latency is 1 cycle after the last byte's rx_valid.
- Read path:
  - RFETCH pulses mem_rden for 1 cycle, RWAIT counts RD_LAT cycles, then the word is captured.
  - In RSEND, tx_byte presents byte[CH_BYTES-1] first; each tx_req advances one byte.
  - After the last byte, the address increments and the FSM returns to RFETCH.
  - A tx_req arriving while the FSM is not in RSEND returns tx_byte=8'h00 and sets err (underrun). In read mode, rx bytes are ignored.
- Control byte: bit0 → proc_enable, bit2 → sel_ext (both level, held); bit1=1 → proc_reset high for RST_PULSE cycles; bit7=1 → clear err. Subsequent control bytes in the same frame are also applied.
- frame_end in any state → IDLE next cycle.
  - A partially assembled write word is discarded with no wren.
  - A read fetch in flight is abandoned and tx_byte returns to 8'h00.
- rx_valid and frame_end in the same cycle: the byte is processed first, then the FSM goes to IDLE.
- frame_start while busy: treated as frame_end followed by a new frame, so the FSM goes to HDR.
- Address wrap: all-ones increments to 0, no error.
- The proc_reset pulse counter is independent of the FSM and continues across frames. Only reset clears it.
- reset mid-frame: immediate return to reset values; a pulsing proc_reset drops to 0.

Decomposition:
- Shared package holds:
  - mode encodings: MODE_WR=2'b00, MODE_RD=2'b01, MODE_CTRL=2'b10;
  - state localparams;
  - control bit positions.
- Natural sub-module: spi_word_packer. It covers MSB-first byte-to-word assembly and word-to-byte serialisation, with a byte counter and CH_BYTES lookup. It is reused for both directions.

Test Plan:
- Write to ch0, addr 0x0005, bytes 0xAB 0xCD → mem_wren=3'b001 twice; addr 5 with wdata 0xAB, then addr 6 with 0xCD.
- Write to ch1 with 16 bytes 0x00..0x0F then frame_end → one mem_wren=3'b010 pulse; wdata=128'h000102…0F; no wren on a 17th partial byte.
- Read ch2 at addr 0x0003 with mem_rdata=80'h112233445566778899AA (RD_LAT=2) → tx_byte sequence 0x11..0xAA on 10 tx_reqs; mem_rdena then re-pulses at addr 4.
- Control 0x07 → proc_enable=1, sel_ext=1, proc_reset high for exactly 16 cycles. Control 0x80 → err cleared.
- Header 0x3F (channel 63) → err=1, no wren or rden for the rest of the frame; the next valid frame still works.
- Write at addr 0x7FFF with 2 bytes on ch0 → writes at 0x7FFF and 0x0000. reset asserted mid-word → no wren, all outputs 0.
